// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and FSM states.
package lsu_pkg;

  localparam int unsigned WORD_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_t;

endpackage

// File: rtl/lsu_lane_fmt.sv
// Lane formatting: load extract + sign/zero extend, sub-word store merge.
// LSU_BIG_ENDIAN_EN selects inverted byte/half lanes for both directions.
module lsu_lane_fmt
  import lsu_pkg::*;
(
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [1:0]        offset,
  input  logic [WORD_W-1:0] rdata,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merge_data
);

  logic [1:0]  lane;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

`ifdef LSU_BIG_ENDIAN_EN
  assign lane = ~offset;
`else
  assign lane = offset;
`endif

  // Load path: pick the lane, then extend to a full word.
  always_comb begin
    byte_sel = rdata[7:0];
    case (lane)
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      2'd3:    byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: load_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: load_data = rdata;
    endcase
  end

  // Store path: overwrite only the addressed lane(s) of the old word.
  always_comb begin
    merge_data = rdata;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd1:    merge_data[15:8]  = wdata[7:0];
          2'd2:    merge_data[23:16] = wdata[7:0];
          2'd3:    merge_data[31:24] = wdata[7:0];
          default: merge_data[7:0]   = wdata[7:0];
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) merge_data[31:16] = wdata[15:0];
        else         merge_data[15:0]  = wdata[15:0];
      end
      default: merge_data = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage front end of the data cache: word-aligned accesses, RMW for sub-word
// stores, miss reissue. Build option LSU_BIG_ENDIAN_EN (see lsu_lane_fmt).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_size,
  input  logic                  mem_unsigned,
  input  logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  mem_done,
  output logic                  mem_busy,
  output logic                  mem_misalign,
  output logic [ADDR_WIDTH-1:0] cache_addr,
  output logic [DATA_WIDTH-1:0] cache_wdata,
  output logic                  cache_en,
  output logic                  cache_wen,
  output logic                  cache_byte_en,
  input  logic [DATA_WIDTH-1:0] cache_rdata,
  input  logic                  cache_hit,
  input  logic                  cache_stall
);

  state_t                state;
  logic                  en_q;
  logic                  stalled;
  logic [1:0]            off_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  waiting;
  logic                  sub_word;
  logic                  reissue;
  logic [DATA_WIDTH-1:0] load_data;
  logic [DATA_WIDTH-1:0] merge_data;

  assign mem_misalign = (mem_size == SZ_HALF && mem_addr[0]) ||
                        (mem_size[1] && mem_addr[1:0] != 2'b00);
  assign sub_word     = mem_we && !mem_size[1];
  assign waiting      = (state == S_ACC) || (state == S_RMW_RD) || (state == S_RMW_WR);
  assign mem_busy     = waiting || (state == S_IDLE && mem_req && !mem_misalign);
  assign cache_byte_en = 1'b1;

  // Refill finished without a hit: replay the held access in this very cycle so the
  // post-refill hit lands as early as possible. Address/data registers are unchanged.
  assign reissue  = waiting && stalled && !cache_hit && !cache_stall;
  assign cache_en = en_q || reissue;

  lsu_lane_fmt u_fmt (
    .size        (size_q),
    .is_unsigned (uns_q),
    .offset      (off_q),
    .rdata       (cache_rdata),
    .wdata       (wdata_q),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      en_q        <= 1'b0;
      stalled     <= 1'b0;
      cache_wen   <= 1'b0;
      cache_addr  <= '0;
      cache_wdata <= '0;
      mem_rdata   <= '0;
      mem_done    <= 1'b0;
      off_q       <= 2'b00;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
    end else begin
      en_q     <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (mem_req && !mem_misalign) begin
            en_q        <= 1'b1;
            stalled     <= 1'b0;
            cache_addr  <= {mem_addr[ADDR_WIDTH-1:2], 2'b00};
            cache_wen   <= mem_we && !sub_word;
            cache_wdata <= mem_wdata;
            off_q       <= mem_addr[1:0];
            size_q      <= mem_size;
            uns_q       <= mem_unsigned;
            we_q        <= mem_we;
            wdata_q     <= mem_wdata;
            state       <= sub_word ? S_RMW_RD : S_ACC;
          end
        end
        S_ACC: begin
          if (cache_hit) begin
            if (!we_q) mem_rdata <= load_data;
            mem_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            stalled <= cache_stall;
          end
        end
        S_RMW_RD: begin
          if (cache_hit) begin
            en_q        <= 1'b1;
            stalled     <= 1'b0;
            cache_wen   <= 1'b1;
            cache_wdata <= merge_data;
            state       <= S_RMW_WR;
          end else begin
            stalled <= cache_stall;
          end
        end
        S_RMW_WR: begin
          if (cache_hit) begin
            mem_done <= 1'b1;
            state    <= S_DONE;
          end else begin
            stalled <= cache_stall;
          end
        end
        S_DONE: begin
          cache_wen <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
